mul16_seq: RTL and testbench

Sequential 16×16 shift-and-add multiplier. It produces a 32-bit product over 16 iteration cycles and consumes one 16-bit carry-lookahead adder (Adder16) as its only arithmetic datapath element. It sits between the operand register file and the result writeback register in the exp1 datapath, and gives the CPU experiments a multi-cycle MUL unit with a start/done handshake.

---
 rtl/mul16_seq.sv | 168 ++++++++++++++++
 tb/tb_mul16_seq.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/mul16_seq.sv
// Sequential 16x16 shift-and-add multiplier built around one 16-bit carry-lookahead adder.
// Define MUL16_SIGNED_EN for two's complement operands and product; default is unsigned.

module Adder16 (
   input  logic [15:0] A,
   input  logic [15:0] B,
   input  logic        Cin,
   output logic [15:0] Sum,
   output logic        Gx,
   output logic        Px,
   output logic        C14
);

   logic [15:0] g, p, c;
   logic [3:0]  gg, gp, cg;
   logic [2:0]  cc;

   // Carries into bit positions 1..3 of a 4-bit lookahead block.
   function automatic logic [2:0] cla3(input logic [3:0] gi, input logic [3:0] pi,
                                       input logic ci);
      logic [2:0] co;
      co[0] = gi[0] | (pi[0] & ci);
      co[1] = gi[1] | (pi[1] & gi[0]) | (pi[1] & pi[0] & ci);
      co[2] = gi[2] | (pi[2] & gi[1]) | (pi[2] & pi[1] & gi[0]) | (pi[2] & pi[1] & pi[0] & ci);
      return co;
   endfunction

   function automatic logic gen4(input logic [3:0] gi, input logic [3:0] pi);
      return gi[3] | (pi[3] & gi[2]) | (pi[3] & pi[2] & gi[1]) | (pi[3] & pi[2] & pi[1] & gi[0]);
   endfunction

   always_comb begin
      g = A & B;
      p = A ^ B;
      for (int i = 0; i < 4; i++) begin
         gg[i] = gen4(g[4*i +: 4], p[4*i +: 4]);
         gp[i] = &p[4*i +: 4];
      end
      cg = {cla3(gg, gp, Cin), Cin};
      c  = '0;
      for (int i = 0; i < 4; i++) begin
         cc           = cla3(g[4*i +: 4], p[4*i +: 4], cg[i]);
         c[4*i +: 4]  = {cc, cg[i]};
      end
      Sum = p ^ c;
      Gx  = gen4(gg, gp);
      Px  = &gp;
      C14 = c[15];
   end

endmodule

module mul16_seq (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        Start,
   input  logic [15:0] A,
   input  logic [15:0] B,
   output logic        Busy,
   output logic        Done,
   output logic [31:0] P
);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

   state_t      state_q, state_d;
   logic [15:0] mcand_q, mcand_d;
   logic [15:0] acc_q, acc_d;
   logic [15:0] q_q, q_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [31:0] p_q, p_d;
   logic [15:0] sum;
   logic        carry;
   logic [15:0] a_op, b_op;
   logic [31:0] prod, prod_fix;

`ifdef MUL16_SIGNED_EN
   logic neg_q, neg_d;
   assign a_op     = A[15] ? (~A + 16'd1) : A;
   assign b_op     = B[15] ? (~B + 16'd1) : B;
   assign prod_fix = neg_q ? (~prod + 32'd1) : prod;
`else
   assign a_op     = A;
   assign b_op     = B;
   assign prod_fix = prod;
`endif

   // With Cin tied low the group generate is the adder's carry-out.
   Adder16 u_add (
      .A   (acc_q),
      .B   (mcand_q),
      .Cin (1'b0),
      .Sum (sum),
      .Gx  (carry),
      .Px  (),
      .C14 ()
   );

   // The carry is absorbed by the same-cycle shift, so no 17th accumulator bit is stored.
   assign prod = q_q[0] ? {carry, sum, q_q[15:1]} : {1'b0, acc_q, q_q[15:1]};

   always_comb begin
      state_d = state_q;
      mcand_d = mcand_q;
      acc_d   = acc_q;
      q_d     = q_q;
      cnt_d   = cnt_q;
      p_d     = p_q;
`ifdef MUL16_SIGNED_EN
      neg_d   = neg_q;
`endif
      unique case (state_q)
         StRun: begin
            acc_d = prod[31:16];
            q_d   = prod[15:0];
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd15) begin
               state_d = StDone;
               p_d     = prod_fix;
            end
         end
         StIdle, StDone: begin
            if (Start) begin
               state_d = StRun;
               mcand_d = a_op;
               q_d     = b_op;
               acc_d   = '0;
               cnt_d   = '0;
`ifdef MUL16_SIGNED_EN
               neg_d   = A[15] ^ B[15];
`endif
            end else begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
         mcand_q <= '0;
         acc_q   <= '0;
         q_q     <= '0;
         cnt_q   <= '0;
         p_q     <= '0;
`ifdef MUL16_SIGNED_EN
         neg_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         mcand_q <= mcand_d;
         acc_q   <= acc_d;
         q_q     <= q_d;
         cnt_q   <= cnt_d;
         p_q     <= p_d;
`ifdef MUL16_SIGNED_EN
         neg_q   <= neg_d;
`endif
      end
   end

   assign Busy = (state_q == StRun);
   assign Done = (state_q == StDone);
   assign P    = p_q;

endmodule

// File: tb/tb_mul16_seq.sv
// Scoreboard bench for mul16_seq: stimulus pushes expected product and Done cycle, a monitor
// pops on every Done pulse. Honours MUL16_SIGNED_EN for the operand-sign-dependent vectors.

module tb_mul16_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        Start;
   logic [15:0] A, B;
   logic        Busy, Done;
   logic [31:0] P;

   int          n_vec = 0;
   int          n_err = 0;
   int          cyc   = 0;
   logic [31:0] exp_q[$];
   int          expc_q[$];

   mul16_seq dut (
      .clk   (clk),
      .rst_n (rst_n),
      .Start (Start),
      .A     (A),
      .B     (B),
      .Busy  (Busy),
      .Done  (Done),
      .P     (P)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Monitor: Busy/Done exclusion every cycle; product and latency on each Done.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         check("busy_done_excl", {31'd0, Busy & Done}, 32'd0);
         if (Done === 1'b1) begin
            if (exp_q.size() == 0) begin
               check("unexpected_done", {31'd0, Done}, 32'd0);
            end else begin
               check("product", P, exp_q.pop_front());
               check("done_latency", cyc, expc_q.pop_front());
            end
         end
      end
   end

   task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [31:0] e);
      @(negedge clk);
      A     = a;
      B     = b;
      Start = 1'b1;
      @(posedge clk);
      #1;
      exp_q.push_back(e);
      expc_q.push_back(cyc + 16);
      Start = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 80; i++) begin
         if (exp_q.size() == 0) break;
         @(negedge clk);
      end
      if (exp_q.size() != 0) begin
         check("done_timeout", exp_q.size(), 32'd0);
         exp_q.delete();
         expc_q.delete();
      end
   endtask

   initial begin
      int bc;
      rst_n = 1'b0;
      Start = 1'b0;
      A     = '0;
      B     = '0;
      repeat (2) @(negedge clk);
      check("reset_busy", {31'd0, Busy}, 32'd0);
      check("reset_done", {31'd0, Done}, 32'd0);
      check("reset_p", P, 32'd0);
      rst_n = 1'b1;

      // Basic handshake: 16 Busy cycles, then Done, then P held.
      issue(16'd3, 16'd5, 32'h0000_000F);
      bc = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (Done) break;
         if (Busy) bc++;
      end
      check("busy_cycles", bc, 32'd16);
      drain();
      repeat (3) @(negedge clk);
      check("p_held", P, 32'h0000_000F);
      check("done_one_cycle", {31'd0, Done}, 32'd0);

`ifdef MUL16_SIGNED_EN
      issue(16'hFFFE, 16'd3, 32'hFFFF_FFFA);      drain();
      issue(16'h8000, 16'h8000, 32'h4000_0000);   drain();
      issue(16'hFFFF, 16'hFFFF, 32'h0000_0001);   drain();
      issue(16'd7, 16'hFFF7, 32'hFFFF_FFC1);      drain();
`else
      issue(16'hFFFF, 16'hFFFF, 32'hFFFE_0001);   drain();
      issue(16'h0000, 16'h1234, 32'h0000_0000);   drain();
      issue(16'h1234, 16'h5678, 32'h0626_0060);   drain();
      issue(16'h8000, 16'h8000, 32'h4000_0000);   drain();
`endif

      // Start held high: second op accepted in the DONE cycle; operands changed mid-run.
      @(negedge clk);
      A     = 16'd7;
      B     = 16'd9;
      Start = 1'b1;
      @(posedge clk);
      #1;
      exp_q.push_back(32'd63);
      expc_q.push_back(cyc + 16);
`ifdef MUL16_SIGNED_EN
      exp_q.push_back(32'hFFFF_0000);
`else
      exp_q.push_back(32'h0001_0000);
`endif
      expc_q.push_back(cyc + 33);
      A = 16'h8000;
      B = 16'd2;
      repeat (17) @(posedge clk);
      #1;
      Start = 1'b0;
      drain();

      // Start during RUN is ignored.
      issue(16'd100, 16'd200, 32'd20000);
      repeat (5) @(negedge clk);
      A     = 16'd1;
      B     = 16'd1;
      Start = 1'b1;
      @(negedge clk);
      Start = 1'b0;
      drain();

      // Reset mid-run, with Start asserted on the same edge.
      @(negedge clk);
      A     = 16'd9;
      B     = 16'd9;
      Start = 1'b1;
      @(posedge clk);
      #1;
      Start = 1'b0;
      repeat (7) @(negedge clk);
      rst_n = 1'b0;
      Start = 1'b1;
      @(negedge clk);
      check("abort_busy", {31'd0, Busy}, 32'd0);
      check("abort_done", {31'd0, Done}, 32'd0);
      check("abort_p", P, 32'd0);
      rst_n = 1'b1;
      Start = 1'b0;
      repeat (20) @(negedge clk);
      check("abort_stays_idle", {30'd0, Busy, Done}, 32'd0);
      issue(16'd2, 16'd2, 32'd4);
      drain();

      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

endmodule
